// File: rtl/mitchell_log_adder.sv
// ---------------------------------------------------------------------------
// mitchell_log_adder
//
// Front end of a Mitchell approximate multiplier. Two unsigned 8-bit operands
// are encoded into fixed-point log2 approximations {k[2:0], f[6:0]}. The two
// logs are then added into the 11-bit log-sum word {int[3:0], frac[6:0]} that
// the antilog decoder consumes. A zero operand cannot be log-encoded, so it is
// flagged instead. The downstream logic then forces the product to 0.
//
// Two-stage stall pipeline. Stage 1 encodes and stage 2 adds. Each stage
// advances when the stage after it is empty or is draining.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand pair present
//   in_ready   pair accepted this cycle (combinational from out_ready)
//   op_a       unsigned 8-bit multiplicand
//   op_b       unsigned 8-bit multiplier
//   out_valid  log_sum/zero valid
//   out_ready  downstream consumes this cycle
//   log_sum    {int[3:0], frac[6:0]} log-domain sum
//   zero       op_a==0 or op_b==0; product must be forced to 0
// ---------------------------------------------------------------------------
module mitchell_log_adder (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  op_a,
   input  logic [7:0]  op_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [10:0] log_sum,
   output logic        zero
);

   // Mitchell encoding: characteristic = leading-one index, mantissa = the
   // bits below it, left-aligned. x == 0 encodes to 0 because the shifted
   // value is 0 and no bit ever raises k.
   function automatic logic [9:0] encode(input logic [7:0] x);
      logic [2:0] k;
      logic [7:0] sh;
      k = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (x[i]) k = 3'(i);
      end
      sh = x << (3'd7 - k);
      return {k, sh[6:0]};
   endfunction

   logic       v1;
   logic       v2;
   logic [9:0] log_a;
   logic [9:0] log_b;
   logic       zero_1;
   logic       en1;
   logic       en2;

   // A stage may load when it is empty or when its contents move on this edge.
   // in_ready therefore depends combinationally on out_ready. This allows a
   // full pipeline to accept new data in the same cycle that it drains.
   assign en2       = !v2 || out_ready;
   assign en1       = !v1 || en2;
   assign in_ready  = en1;
   assign out_valid = v2;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others. This keeps stage 1
   // feeding stage 2 order-independent.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the data registers are reset along with the valids because
         // log_sum and zero are visible ports and must read 0 after reset.
         v1      <= 1'b0;
         v2      <= 1'b0;
         log_a   <= 10'h000;
         log_b   <= 10'h000;
         zero_1  <= 1'b0;
         log_sum <= 11'h000;
         zero    <= 1'b0;
      end else begin
         if (en1) begin
            v1 <= in_valid;
            if (in_valid) begin
               log_a  <= encode(op_a);
               log_b  <= encode(op_b);
               zero_1 <= (op_a == 8'd0) || (op_b == 8'd0);
            end
         end
         if (en2) begin
            v2 <= v1;
            if (v1) begin
               // Max 0x3FF + 0x3FF = 0x7FE, so the sum cannot overflow.
               // The fraction carry ripples into the integer field.
               log_sum <= zero_1 ? 11'h000 : ({1'b0, log_a} + {1'b0, log_b});
               zero    <= zero_1;
            end
         end
      end
   end

endmodule
